rob_commit_ctrl: RTL
====================

ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16, the number of ROB slots; slot 0 is reserved as the "no tag" value, so slots 1..ROB_SIZE-1 are usable.
REQ-002 SHALL have ports: clk_in  input  1  clock, single clock domain.
REQ-003 SHALL have: rst_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have: rdy_in  input  1  global enable; when low, all state holds.
REQ-005 SHALL have: alloc_en_in  input  1  issue requests one slot.
REQ-006 SHALL have: alloc_rd_in  input  5  destination register.
REQ-007 SHALL have: alloc_wr_rd_in  input  1  instruction writes rd.
REQ-008 SHALL have: alloc_is_branch_in  input  1  instruction is a branch.
REQ-009 SHALL have: alloc_rob_pos_out  output  ROBIdxWidth  current tail slot (combinational).
REQ-010 SHALL have: full_out  output  1  no free slot (combinational).
REQ-011 SHALL have: cdb_en_in  input  1, cdb_rob_pos_in  input  ROBIdxWidth, cdb_res_in  input  WordWidth, cdb_mispredict_in  input  1, cdb_target_in  input  WordWidth; these form the result broadcast.
REQ-012 SHALL have: commit_to_regfile_en_out  output  1, commit_to_regfile_rd_out  output  RegIdxWidth, commit_to_regfile_rob_pos_out  output  ROBIdxWidth, commit_to_regfile_res_out  output  WordWidth.
REQ-013 SHALL have: clear_branch_out  output  1  flush pulse; redirect_pc_out  output  WordWidth  corrected PC.

Function
REQ-014 SHALL hold per slot: valid, ready, wr_rd, is_branch, mispredict, rd, res, target; plus head, tail and count registers.
REQ-015 SHALL set full_out when count == ROB_SIZE-1.
REQ-016 SHALL, on alloc_en_in && !full_out, write the tail slot with valid=1 and ready=0, and advance tail.
REQ-017 SHALL ignore alloc_en_in while full_out is high; the requester holds the request.
REQ-018 SHALL advance head and tail modulo wrap from ROB_SIZE-1 to 1, never to 0.
REQ-019 SHALL, on cdb_en_in addressing a valid slot, store res, target and mispredict, and set ready; a CDB write to an invalid slot or to slot 0 SHALL be ignored.
REQ-020 SHALL commit at most one entry per cycle, in order; the head commits when it is valid and ready as registered state (a CDB write at edge k allows commit outputs at edge k+1).
REQ-021 SHALL register all commit outputs; commit_to_regfile_en_out is a 1-cycle pulse and is asserted only if wr_rd=1 and rd!=0; entries without a write still retire silently.
REQ-022 SHALL drive commit_to_regfile_rob_pos_out with the head slot index.
REQ-023 SHALL, when a committing head has is_branch=1 and mispredict=1, pulse clear_branch_out for 1 cycle and drive redirect_pc_out=target, and clear all valid bits, set head=tail=1 and count=0.
REQ-024 SHALL give flush priority over a same-cycle allocation (the allocation is dropped) and over a same-cycle CDB write.
REQ-025 SHALL, on a same-cycle allocate and commit, leave count unchanged; allocation into the slot being freed is legal only when count was full-1 after the commit.
REQ-026 SHALL, when rdy_in is low, hold all state and deassert all pulse outputs.

Reset
REQ-027 SHALL, on rst_in low, immediately clear all valid/ready bits, set head=tail=1 and count=0, and zero all registered outputs.
REQ-028 SHALL, on reset asserted mid-operation, discard in-flight entries and emit no commit or clear pulse.

Structure
REQ-029 SHALL take WordWidth, RegIdxWidth, ROBIdxWidth, RegSize and ZERO from the shared config header; ROB_SIZE SHALL be derived from ROBIdxWidth there.
REQ-030 SHALL be a single module; the slot-index increment-with-skip-0 SHALL be one internal function, not a sub-module.

Verification
REQ-031 Allocate 3 with rd=5,6,7; CDB slots 3, 1, 2 with res A/B/C -> commits rd5=B, rd6=C, rd7=A in order, pos 1,2,3.
REQ-032 Allocate 15 -> full_out=1; alloc_pos wraps 15->1 after head retires; a 16th alloc held off is accepted the cycle after a commit.
REQ-033 Branch at slot 2 with mispredict=1 and target 0x1000, younger slot 3 ready -> clear_branch_out pulse, redirect 0x1000, slot 3 never commits, next alloc_rob_pos_out=1.
REQ-034 Entry with rd=0 or wr_rd=0 ready -> head advances, commit_to_regfile_en_out stays 0.
REQ-035 Reset asserted while 4 entries are pending -> outputs 0 immediately, count=0, no pulses after release.
REQ-036 rdy_in low for 3 cycles with ready head -> no commit; commit occurs the first cycle after rdy_in returns high.

Source files
------------

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared configuration for the reorder-buffer commit controller: datapath widths,
// ROB geometry and the common index/word types.
package rob_commit_ctrl_pkg;

  localparam int unsigned WordWidth   = 32;
  localparam int unsigned RegSize     = 32;
  localparam int unsigned RegIdxWidth = $clog2(RegSize);
  localparam int unsigned ROBIdxWidth = 4;
  // Slot 0 is the "no tag" value, so only ROB_SIZE-1 slots hold instructions.
  localparam int unsigned ROB_SIZE    = 1 << ROBIdxWidth;

  localparam logic [WordWidth-1:0] ZERO = '0;

  typedef logic [WordWidth-1:0]   word_t;
  typedef logic [RegIdxWidth-1:0] reg_idx_t;
  typedef logic [ROBIdxWidth-1:0] rob_idx_t;

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Issue, result-broadcast and commit signals of the ROB commit controller.
// master: issue stage / CDB / regfile side; slave: the ROB itself.
interface rob_commit_ctrl_if;
  import rob_commit_ctrl_pkg::*;

  // Allocation from issue
  logic     alloc_en_in;
  reg_idx_t alloc_rd_in;
  logic     alloc_wr_rd_in;
  logic     alloc_is_branch_in;
  rob_idx_t alloc_rob_pos_out;
  logic     full_out;

  // Common data bus result broadcast
  logic     cdb_en_in;
  rob_idx_t cdb_rob_pos_in;
  word_t    cdb_res_in;
  logic     cdb_mispredict_in;
  word_t    cdb_target_in;

  // Commit to register file and branch recovery
  logic     commit_to_regfile_en_out;
  reg_idx_t commit_to_regfile_rd_out;
  rob_idx_t commit_to_regfile_rob_pos_out;
  word_t    commit_to_regfile_res_out;
  logic     clear_branch_out;
  word_t    redirect_pc_out;

  modport master (
    output alloc_en_in, alloc_rd_in, alloc_wr_rd_in, alloc_is_branch_in,
    output cdb_en_in, cdb_rob_pos_in, cdb_res_in, cdb_mispredict_in, cdb_target_in,
    input  alloc_rob_pos_out, full_out,
    input  commit_to_regfile_en_out, commit_to_regfile_rd_out,
    input  commit_to_regfile_rob_pos_out, commit_to_regfile_res_out,
    input  clear_branch_out, redirect_pc_out
  );

  modport slave (
    input  alloc_en_in, alloc_rd_in, alloc_wr_rd_in, alloc_is_branch_in,
    input  cdb_en_in, cdb_rob_pos_in, cdb_res_in, cdb_mispredict_in, cdb_target_in,
    output alloc_rob_pos_out, full_out,
    output commit_to_regfile_en_out, commit_to_regfile_rd_out,
    output commit_to_regfile_rob_pos_out, commit_to_regfile_res_out,
    output clear_branch_out, redirect_pc_out
  );

endinterface

// File: rtl/rob_commit_ctrl.sv
// Reorder buffer with in-order single-entry commit and mispredict flush.
// Slots 1..ROB_SIZE-1 form a ring; slot 0 is never allocated.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int unsigned ROB_SIZE = rob_commit_ctrl_pkg::ROB_SIZE
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  rob_commit_ctrl_if.slave bus
);

  localparam rob_idx_t LastSlot = rob_idx_t'(ROB_SIZE - 1);
  localparam rob_idx_t FirstSlot = rob_idx_t'(1);

  // Ring increment that skips the reserved slot 0.
  function automatic rob_idx_t next_slot(input rob_idx_t idx);
    return (idx == LastSlot) ? FirstSlot : idx + rob_idx_t'(1);
  endfunction

  // Per-slot state
  logic [ROB_SIZE-1:0] valid_q, ready_q, wr_rd_q, is_branch_q, mispredict_q;
  reg_idx_t            rd_q     [ROB_SIZE];
  word_t               res_q    [ROB_SIZE];
  word_t               target_q [ROB_SIZE];

  rob_idx_t head_q, head_d, tail_q, tail_d, count_q, count_d;

  // Registered commit outputs
  logic     commit_en_q, clear_q;
  reg_idx_t commit_rd_q;
  rob_idx_t commit_pos_q;
  word_t    commit_res_q, redirect_q;

  logic full, commit, flush, alloc_ok, cdb_ok, head_writes;

  // Decode this cycle's commit / flush / alloc / CDB actions from registered state.
  always_comb begin
    full        = (count_q == LastSlot);
    commit      = rdy_in && valid_q[head_q] && ready_q[head_q];
    flush       = commit && is_branch_q[head_q] && mispredict_q[head_q];
    head_writes = wr_rd_q[head_q] && (rd_q[head_q] != '0);
    alloc_ok    = rdy_in && bus.alloc_en_in && !full && !flush;
    cdb_ok      = rdy_in && bus.cdb_en_in && (bus.cdb_rob_pos_in != '0) &&
                  valid_q[bus.cdb_rob_pos_in] && !flush;
  end

  // Next head/tail/count; a flush rewinds the ring to empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = FirstSlot;
      tail_d  = FirstSlot;
      count_d = '0;
    end else begin
      if (commit)   head_d = next_slot(head_q);
      if (alloc_ok) tail_d = next_slot(tail_q);
      unique case ({alloc_ok, commit})
        2'b10:   count_d = count_q + rob_idx_t'(1);
        2'b01:   count_d = count_q - rob_idx_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and commit-output registers; pulses fall whenever nothing commits.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q       <= FirstSlot;
      tail_q       <= FirstSlot;
      count_q      <= '0;
      commit_en_q  <= 1'b0;
      clear_q      <= 1'b0;
      commit_rd_q  <= '0;
      commit_pos_q <= '0;
      commit_res_q <= ZERO;
      redirect_q   <= ZERO;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      commit_en_q <= commit && head_writes;
      clear_q     <= flush;
      if (commit) begin
        commit_rd_q  <= rd_q[head_q];
        commit_pos_q <= head_q;
        commit_res_q <= res_q[head_q];
      end
      if (flush) redirect_q <= target_q[head_q];
    end
  end

  // Slot array updates: CDB result capture, retirement and allocation.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q      <= '0;
      ready_q      <= '0;
      wr_rd_q      <= '0;
      is_branch_q  <= '0;
      mispredict_q <= '0;
      for (int i = 0; i < int'(ROB_SIZE); i++) begin
        rd_q[i]     <= '0;
        res_q[i]    <= ZERO;
        target_q[i] <= ZERO;
      end
    end else if (flush) begin
      valid_q <= '0;
      ready_q <= '0;
    end else begin
      if (cdb_ok) begin
        ready_q[bus.cdb_rob_pos_in]      <= 1'b1;
        res_q[bus.cdb_rob_pos_in]        <= bus.cdb_res_in;
        target_q[bus.cdb_rob_pos_in]     <= bus.cdb_target_in;
        mispredict_q[bus.cdb_rob_pos_in] <= bus.cdb_mispredict_in;
      end
      if (commit) begin
        valid_q[head_q] <= 1'b0;
        ready_q[head_q] <= 1'b0;
      end
      // Tail never equals a valid head here: alloc is blocked while full.
      if (alloc_ok) begin
        valid_q[tail_q]      <= 1'b1;
        ready_q[tail_q]      <= 1'b0;
        wr_rd_q[tail_q]      <= bus.alloc_wr_rd_in;
        is_branch_q[tail_q]  <= bus.alloc_is_branch_in;
        mispredict_q[tail_q] <= 1'b0;
        rd_q[tail_q]         <= bus.alloc_rd_in;
      end
    end
  end

  assign bus.alloc_rob_pos_out             = tail_q;
  assign bus.full_out                      = full;
  assign bus.commit_to_regfile_en_out      = commit_en_q;
  assign bus.commit_to_regfile_rd_out      = commit_rd_q;
  assign bus.commit_to_regfile_rob_pos_out = commit_pos_q;
  assign bus.commit_to_regfile_res_out     = commit_res_q;
  assign bus.clear_branch_out              = clear_q;
  assign bus.redirect_pc_out               = redirect_q;

endmodule
